// File: rtl/zbus_pkg.sv
// Shared definitions for the Z80 I/O initiator: FSM encoding, idle bus value,
// settle-counter width and the bus-condition helper.
package zbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;
  localparam int         SETTLE_W      = 4;

  // INTA (IORQ and M1 both low) is excluded; exactly one of RD/WR must be low.
  function automatic logic io_valid(input logic iorq_s, input logic rd_s,
                                    input logic wr_s, input logic m1_s);
    return (!iorq_s) && m1_s && (rd_s ^ wr_s);
  endfunction

endpackage

// File: rtl/zbus_io_initiator_if.sv
// Port-side interface between the Z80 I/O initiator and the TSXB port decoder.
interface zbus_io_initiator_if;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        rnw;
  logic        port_en;
  logic        port_req;

  modport master (output addr, output data_out, output rnw, output port_req,
                  input data_in, input port_en);
  modport slave  (input addr, input data_out, input rnw, input port_req,
                  output data_in, output port_en);
endinterface

// File: rtl/zbus_sync.sv
// Multi-stage synchroniser for an active-low asynchronous control; idles high.
module zbus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; reset to the inactive (high) level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/zbus_io_initiator.sv
// Z80 I/O bus front end: synchronises and settles bus cycles, captures
// address/data, queries the decoder and strobes port_req once per claimed cycle.
module zbus_io_initiator
  import zbus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          z_a,
  input  logic [7:0]           z_d_in,
  output logic [7:0]           z_d_out,
  output logic                 z_d_oe,
  input  logic                 z_iorq_n,
  input  logic                 z_rd_n,
  input  logic                 z_wr_n,
  input  logic                 z_m1_n,
  zbus_io_initiator_if.master  port_if,
  output logic                 busy
);

  localparam int                FLUSH_W  = $clog2(SYNC_STAGES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_C = SETTLE_W'(SETTLE);
  localparam logic [FLUSH_W-1:0]  FLUSH_C  = FLUSH_W'(SYNC_STAGES);

  logic iorq_s, rd_s, wr_s, m1_s;
  logic valid_s, flush_done_s;

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [FLUSH_W-1:0]  flush_q, flush_d;
  logic                armed_q, armed_d;
  logic                dir_q, dir_d;
  logic [15:0]         addr_q, addr_d;
  logic [7:0]          data_out_q, data_out_d;
  logic                rnw_q, rnw_d;
  logic                port_req_q, port_req_d;
  logic [7:0]          z_d_out_q, z_d_out_d;
  logic                z_d_oe_q, z_d_oe_d;
  logic                busy_q, busy_d;

  zbus_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (.clk(clk), .rst_n(rst_n), .d_i(z_iorq_n), .q_o(iorq_s));
  zbus_sync #(.STAGES(SYNC_STAGES)) u_sync_rd   (.clk(clk), .rst_n(rst_n), .d_i(z_rd_n),   .q_o(rd_s));
  zbus_sync #(.STAGES(SYNC_STAGES)) u_sync_wr   (.clk(clk), .rst_n(rst_n), .d_i(z_wr_n),   .q_o(wr_s));
  zbus_sync #(.STAGES(SYNC_STAGES)) u_sync_m1   (.clk(clk), .rst_n(rst_n), .d_i(z_m1_n),   .q_o(m1_s));

  assign valid_s = io_valid(iorq_s, rd_s, wr_s, m1_s);
  // The synchroniser outputs read 1 straight after reset; arming waits until
  // the chain holds real samples so a cycle already in flight is not seen as idle.
  assign flush_done_s = (flush_q == FLUSH_C);

  // Next-state and registered-output logic for the bus-cycle FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    rnw_d      = rnw_q;
    port_req_d = 1'b0;
    z_d_out_d  = z_d_out_q;
    z_d_oe_d   = z_d_oe_q;
    busy_d     = busy_q;
    dir_d      = rd_s;
    armed_d    = armed_q | (iorq_s & flush_done_s);
    flush_d    = flush_done_s ? flush_q : (flush_q + FLUSH_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (valid_s && armed_q && ((cnt_q == '0) || (rd_s == dir_q))) begin
          if (cnt_q == SETTLE_C) begin
            addr_d  = z_a;
            rnw_d   = !rd_s;
            if (rd_s) begin
              data_out_d = z_d_in;
            end else begin
              data_out_d = data_out_q;
            end
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_DECODE;
          end else begin
            cnt_d = cnt_q + SETTLE_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_DECODE: begin
        if (port_if.port_en) begin
          port_req_d = 1'b1;
          state_d    = ST_STROBE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_STROBE: begin
        if (rnw_q) begin
          z_d_out_d = port_if.data_in;
          z_d_oe_d  = 1'b1;
        end else begin
          z_d_oe_d = 1'b0;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (iorq_s || (rd_s && wr_s)) begin
          z_d_oe_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      flush_q    <= '0;
      armed_q    <= 1'b0;
      dir_q      <= 1'b1;
      addr_q     <= 16'h0000;
      data_out_q <= BUS_IDLE_DATA;
      rnw_q      <= 1'b1;
      port_req_q <= 1'b0;
      z_d_out_q  <= BUS_IDLE_DATA;
      z_d_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      rnw_q      <= rnw_d;
      port_req_q <= port_req_d;
      z_d_out_q  <= z_d_out_d;
      z_d_oe_q   <= z_d_oe_d;
      busy_q     <= busy_d;
    end
  end

  assign port_if.addr     = addr_q;
  assign port_if.data_out = data_out_q;
  assign port_if.rnw      = rnw_q;
  assign port_if.port_req = port_req_q;
  assign z_d_out          = z_d_out_q;
  assign z_d_oe           = z_d_oe_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_zbus_io_initiator.sv
// Scoreboard bench for zbus_io_initiator: directed Z80 I/O cycles push expected
// strobes; a negedge monitor pops and compares each port_req it observes.
module tb_zbus_io_initiator;

  localparam int SYNC_STAGES = 2;
  localparam int SETTLE      = 2;
  localparam int LAT         = SYNC_STAGES + SETTLE + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] z_a;
  logic [7:0]  z_d_in;
  logic [7:0]  z_d_out;
  logic        z_d_oe;
  logic        z_iorq_n, z_rd_n, z_wr_n, z_m1_n;
  logic        busy;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  zbus_io_initiator_if port_if ();

  // Decoder model: claims any port whose low byte is AF; read data = addr[15:8]^AB.
  assign port_if.port_en = (port_if.addr[7:0] == 8'hAF);
  assign port_if.data_in = port_if.addr[15:8] ^ 8'hAB;

  zbus_io_initiator #(.SYNC_STAGES(SYNC_STAGES), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .z_a(z_a), .z_d_in(z_d_in), .z_d_out(z_d_out),
    .z_d_oe(z_d_oe), .z_iorq_n(z_iorq_n), .z_rd_n(z_rd_n), .z_wr_n(z_wr_n),
    .z_m1_n(z_m1_n), .port_if(port_if.master), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic io_cycle(input logic [15:0] a, input bit is_rd, input logic [7:0] d,
                          input int len, input bit claimed, input logic [7:0] rdata);
    exp_t e;
    @(posedge clk); #1;
    z_a = a; z_d_in = d; z_iorq_n = 1'b0;
    if (is_rd) z_rd_n = 1'b0; else z_wr_n = 1'b0;
    if (claimed) begin
      e.addr = a; e.rnw = is_rd; e.wdata = d; e.rdata = rdata; e.cyc = cyc + LAT;
      exp_q.push_back(e);
    end
    repeat (len) @(posedge clk);
    #1;
    z_iorq_n = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1;
  endtask

  // Monitor: every port_req must match the oldest expected strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (port_if.port_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_port_req: got strobe at addr %h, expected none", port_if.addr);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", 32'(cyc), 32'(e.cyc));
          check("strobe_addr", 32'(port_if.addr), 32'(e.addr));
          check("strobe_rnw", 32'(port_if.rnw), 32'(e.rnw));
          if (!e.rnw) check("strobe_wdata", 32'(port_if.data_out), 32'(e.wdata));
          @(negedge clk);
          check("strobe_width", 32'(port_if.port_req), 32'd0);
          check("oe_after_strobe", 32'(z_d_oe), 32'(e.rnw));
          if (e.rnw) check("read_data_bus", 32'(z_d_out), 32'(e.rdata));
        end
      end
    end
  end

  initial begin
    bit saw;
    rst_n = 1'b0; z_a = 16'h0000; z_d_in = 8'h00;
    z_iorq_n = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1; z_m1_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_z_d_out", 32'(z_d_out), 32'h0000_00FF);
    check("rst_z_d_oe", 32'(z_d_oe), 32'd0);
    check("rst_addr", 32'(port_if.addr), 32'h0000_0000);
    check("rst_data_out", 32'(port_if.data_out), 32'h0000_00FF);
    check("rst_rnw", 32'(port_if.rnw), 32'd1);
    check("rst_port_req", 32'(port_if.port_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);

    // Claimed write to 80AF with data 5A.
    io_cycle(16'h80AF, 1'b0, 8'h5A, 10, 1'b1, 8'h00);
    repeat (4) @(negedge clk);
    check("wr_busy_end", 32'(busy), 32'd0);
    check("wr_oe_end", 32'(z_d_oe), 32'd0);
    check("wr_data_out_held", 32'(port_if.data_out), 32'h0000_005A);

    // Claimed read from 01AF: decoder returns AA, oe holds until 1 clk after iorq_s rises.
    io_cycle(16'h01AF, 1'b1, 8'h33, 10, 1'b1, 8'hAA);
    repeat (3) @(negedge clk);
    check("rd_oe_hold", 32'(z_d_oe), 32'd1);
    check("rd_dout_hold", 32'(z_d_out), 32'h0000_00AA);
    @(negedge clk);
    check("rd_oe_drop", 32'(z_d_oe), 32'd0);
    check("rd_busy_drop", 32'(busy), 32'd0);
    check("rd_keeps_data_out", 32'(port_if.data_out), 32'h0000_005A);
    repeat (3) @(posedge clk);

    // Second claimed write with different data.
    io_cycle(16'h12AF, 1'b0, 8'hC3, 8, 1'b1, 8'h00);
    repeat (6) @(posedge clk);

    // Unclaimed read: captured (busy) but no strobe and no oe.
    io_cycle(16'h0300, 1'b1, 8'h00, 10, 1'b0, 8'h00);
    @(negedge clk);
    check("unclaimed_busy_hold", 32'(busy), 32'd1);
    check("unclaimed_oe", 32'(z_d_oe), 32'd0);
    repeat (3) @(negedge clk);
    check("unclaimed_busy_end", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);

    // INTA: iorq and m1 low, then rd low; must never capture.
    @(posedge clk); #1;
    z_a = 16'h00AF; z_iorq_n = 1'b0; z_m1_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 z_rd_n = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw = saw | busy;
    end
    @(posedge clk); #1;
    z_iorq_n = 1'b1; z_m1_n = 1'b1; z_rd_n = 1'b1;
    check("inta_no_capture", 32'(saw), 32'd0);
    repeat (5) @(posedge clk);

    // Short glitch: raw low for only SETTLE clocks.
    io_cycle(16'h01AF, 1'b1, 8'h00, SETTLE, 1'b0, 8'h00);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw = saw | busy;
    end
    check("glitch_no_capture", 32'(saw), 32'd0);

    // Reset in HOLD with oe driven, cycle still in progress.
    @(posedge clk); #1;
    begin
      exp_t e;
      z_a = 16'h01AF; z_iorq_n = 1'b0; z_rd_n = 1'b0;
      e.addr = 16'h01AF; e.rnw = 1'b1; e.wdata = 8'h00; e.rdata = 8'hAA; e.cyc = cyc + LAT;
      exp_q.push_back(e);
    end
    saw = 1'b0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk);
      saw = z_d_oe;
    end
    check("rstmid_oe_reached", 32'(saw), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_oe_cleared", 32'(z_d_oe), 32'd0);
    check("rstmid_busy_cleared", 32'(busy), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw = saw | busy;
    end
    check("rstmid_no_recapture", 32'(saw), 32'd0);
    @(posedge clk); #1;
    z_iorq_n = 1'b1; z_rd_n = 1'b1;
    repeat (5) @(posedge clk);
    io_cycle(16'h01AF, 1'b1, 8'h00, 10, 1'b1, 8'hAA);
    repeat (5) @(negedge clk);
    check("rstmid_new_busy_end", 32'(busy), 32'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("all_strobes_seen", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
